// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_pkg;

    localparam int S_DEPTH       = 256;
    localparam int BYTE_W        = 8;
    localparam int MAX_KEY_BYTES = 32;
    localparam int MAX_RD_LAT    = 4;

    // Key index and wait counters are sized for the largest legal configuration
    localparam int KIDX_W = $clog2(MAX_KEY_BYTES);
    localparam int WAIT_W = $clog2(MAX_RD_LAT);

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        RD_I,
        WAIT_I,
        CALC_J,
        RD_J,
        WAIT_J,
        WR_J,
        WR_I,
        NEXT
    } ksa_state_t;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Holds the key latched at start and returns byte kidx (MSB-first byte order).
// Latency: key captured one cycle after load; byte select is combinational.
// Backpressure: none; load is a single-cycle strobe from the engine.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [8*KEY_BYTES-1:0] key_in,
    input  logic [KIDX_W-1:0]      kidx,
    output logic [BYTE_W-1:0]      key_byte
);

    logic [8*KEY_BYTES-1:0] key_q;
    logic [8*KEY_BYTES-1:0] key_d;

    // Capture a new key only on an accepted start; otherwise hold
    always_comb begin
        key_d = key_q;
        if (load) begin
            key_d = key_in;
        end
    end

    // Key register
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    // Byte 0 is the most significant byte of the key vector
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KIDX_W'(k)) begin
                key_byte = key_q[8*KEY_BYTES-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key schedule over an external S RAM: optional identity fill, then 256 swap iterations.
// Latency: start to done = 1 + (init_en ? 256 : 0) + 256*(6+2*RD_LAT) cycles.
// Backpressure: none; start is ignored while busy, the RAM port is owned exclusively while busy.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   init_en,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [BYTE_W-1:0]      s_q,
    output logic [BYTE_W-1:0]      s_address,
    output logic [BYTE_W-1:0]      s_data,
    output logic                   s_wren,
    output logic                   busy,
    output logic                   done
);

    localparam logic [BYTE_W-1:0] I_LAST    = BYTE_W'(S_DEPTH - 1);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    ksa_state_t         state_q, state_d;
    logic [BYTE_W-1:0]  i_q, i_d;
    logic [BYTE_W-1:0]  j_q, j_d;
    logic [BYTE_W-1:0]  si_q, si_d;
    logic [BYTE_W-1:0]  sj_q, sj_d;
    logic [KIDX_W-1:0]  kidx_q, kidx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BYTE_W-1:0]  s_address_q, s_address_d;
    logic [BYTE_W-1:0]  s_data_q, s_data_d;
    logic               s_wren_q, s_wren_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               key_load;
    logic [BYTE_W-1:0]  key_byte;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .clk      (clk),
        .reset    (reset),
        .load     (key_load),
        .key_in   (secret_key),
        .kidx     (kidx_q),
        .key_byte (key_byte)
    );

    // Next-state and datapath updates, then RAM port values for the state being entered
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        kidx_d   = kidx_q;
        wait_d   = wait_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        key_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_load = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    kidx_d   = '0;
                    wait_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = init_en ? FILL : RD_I;
                end
            end
            FILL: begin
                i_d = i_q + BYTE_W'(1);
                if (i_q == I_LAST) begin
                    state_d = RD_I;
                end
            end
            RD_I: begin
                wait_d  = '0;
                state_d = WAIT_I;
            end
            WAIT_I: begin
                if (wait_q == WAIT_LAST) begin
                    si_d    = s_q;
                    wait_d  = '0;
                    state_d = CALC_J;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            CALC_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = RD_J;
            end
            RD_J: begin
                wait_d  = '0;
                state_d = WAIT_J;
            end
            WAIT_J: begin
                if (wait_q == WAIT_LAST) begin
                    sj_d    = s_q;
                    wait_d  = '0;
                    state_d = WR_J;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WR_J: begin
                state_d = WR_I;
            end
            WR_I: begin
                state_d = NEXT;
            end
            NEXT: begin
                if (i_q == I_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    i_d     = i_q + BYTE_W'(1);
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = RD_I;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Port outputs are registered, so derive them from the next state and next counters
        s_address_d = '0;
        s_data_d    = '0;
        s_wren_d    = 1'b0;
        unique case (state_d)
            FILL: begin
                s_address_d = i_d;
                s_data_d    = i_d;
                s_wren_d    = 1'b1;
            end
            RD_I, WAIT_I, CALC_J, NEXT: begin
                s_address_d = i_d;
            end
            RD_J, WAIT_J: begin
                s_address_d = j_d;
            end
            WR_J: begin
                s_address_d = j_d;
                s_data_d    = si_d;
                s_wren_d    = 1'b1;
            end
            WR_I: begin
                s_address_d = i_d;
                s_data_d    = sj_d;
                s_wren_d    = 1'b1;
            end
            default: begin
                s_address_d = '0;
            end
        endcase
    end

    // State, counters and registered RAM port; reset wins over start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            kidx_q      <= '0;
            wait_q      <= '0;
            s_address_q <= '0;
            s_data_q    <= '0;
            s_wren_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            kidx_q      <= kidx_d;
            wait_q      <= wait_d;
            s_address_q <= s_address_d;
            s_data_q    <= s_data_d;
            s_wren_q    <= s_wren_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_address = s_address_q;
    assign s_data    = s_data_q;
    assign s_wren    = s_wren_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: two instances (defaults; KEY_BYTES=1/RD_LAT=3) on behavioural RAMs.
// Latency: n/a.
// Backpressure: n/a.
module tb_rc4_ksa_engine;

    typedef logic [7:0] sarr_t [256];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic        start_a, init_a, start_b, init_b;
    logic [23:0] key_a;
    logic [7:0]  key_b;
    logic [7:0]  sq_a, addr_a, data_a, sq_b, addr_b, data_b;
    logic        wren_a, busy_a, done_a, wren_b, busy_b, done_b;

    rc4_ksa_engine #(.KEY_BYTES(3), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .init_en(init_a), .secret_key(key_a),
        .s_q(sq_a), .s_address(addr_a), .s_data(data_a), .s_wren(wren_a),
        .busy(busy_a), .done(done_a)
    );

    rc4_ksa_engine #(.KEY_BYTES(1), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .init_en(init_b), .secret_key(key_b),
        .s_q(sq_b), .s_address(addr_b), .s_data(data_b), .s_wren(wren_b),
        .busy(busy_b), .done(done_b)
    );

    // Behavioural S RAMs: A has 1-cycle read latency, B has 3
    sarr_t mem_a, pre_a, mem_b, pre_b;
    logic  load_a = 1'b0, load_b = 1'b0;
    logic [7:0] pb [3];

    always @(posedge clk) begin
        if (load_a) mem_a <= pre_a;
        else if (wren_a) mem_a[addr_a] <= data_a;
        sq_a <= mem_a[addr_a];
    end

    always @(posedge clk) begin
        if (load_b) mem_b <= pre_b;
        else if (wren_b) mem_b[addr_b] <= data_b;
        pb[0] <= mem_b[addr_b];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign sq_b = pb[2];

    // Write log of whichever instance is running
    logic [15:0] wlog[$];
    logic [15:0] exp_log[$];
    always @(negedge clk) begin
        if (wren_a) wlog.push_back({addr_a, data_a});
        if (wren_b) wlog.push_back({addr_b, data_b});
    end

    sarr_t      model_s;
    logic [7:0] kbuf [32];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic void set_key(input logic [23:0] key, input int klen);
        for (int k = 0; k < 32; k++) kbuf[k] = 8'h00;
        for (int k = 0; k < klen; k++) kbuf[k] = key[8*klen-1-8*k -: 8];
    endfunction

    // Software KSA over an array, also producing the expected write stream
    function automatic void model_run(input sarr_t s0, input bit ie, input int klen);
        sarr_t      s;
        int         j;
        logic [7:0] t;
        exp_log.delete();
        s = s0;
        if (ie) begin
            for (int k = 0; k < 256; k++) begin
                s[k] = 8'(k);
                exp_log.push_back({8'(k), 8'(k)});
            end
        end
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(kbuf[i % klen])) % 256;
            exp_log.push_back({8'(j), s[i]});
            exp_log.push_back({8'(i), s[j]});
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        model_s = s;
    endfunction

    function automatic int mem_diff(input bit sel);
        int d = 0;
        for (int k = 0; k < 256; k++)
            if ((sel ? mem_b[k] : mem_a[k]) !== model_s[k]) d++;
        return d;
    endfunction

    // -1 when the logs agree, otherwise index of first disagreement
    function automatic int log_diff();
        int n = (wlog.size() < exp_log.size()) ? wlog.size() : exp_log.size();
        for (int k = 0; k < n; k++)
            if (wlog[k] !== exp_log[k]) return k;
        if (wlog.size() != exp_log.size()) return n;
        return -1;
    endfunction

    function automatic sarr_t rand_bytes();
        sarr_t s;
        for (int k = 0; k < 256; k++) s[k] = 8'($urandom_range(0, 255));
        return s;
    endfunction

    function automatic sarr_t rand_perm();
        sarr_t      s;
        int         r;
        logic [7:0] t;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        for (int k = 255; k > 0; k--) begin
            r = $urandom_range(0, k);
            t = s[k]; s[k] = s[r]; s[r] = t;
        end
        return s;
    endfunction

    task automatic preload(input bit sel, input sarr_t s);
        @(negedge clk);
        if (sel) begin pre_b = s; load_b = 1'b1; end
        else     begin pre_a = s; load_a = 1'b1; end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    // Launch one run and wait (bounded) for done; glitch >= 0 re-pulses start mid-run
    task automatic run(input bit sel, input bit ie, input logic [23:0] key, input int glitch,
                       output int lat, output bit busy_at_done);
        int n;
        int t0;
        wlog.delete();
        @(negedge clk);
        if (sel) begin start_b = 1'b1; init_b = ie; key_b = key[7:0]; end
        else     begin start_a = 1'b1; init_a = ie; key_a = key; end
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        key_a = $urandom; key_b = 8'($urandom);
        init_a = ~ie; init_b = ~ie;
        lat = -1;
        busy_at_done = 1'b1;
        n = 0;
        while (n < 6000) begin
            if (sel ? done_b : done_a) begin
                lat = cyc - t0;
                busy_at_done = sel ? busy_b : busy_a;
                break;
            end
            if (n == glitch) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_a = 1'b1; init_a = 1'b1; key_a = 24'hABCDEF;
        start_b = 1'b1; init_b = 1'b1; key_b = 8'h5A;
        repeat (3) @(negedge clk);
        n_checks++;
        if (addr_a !== 8'h00) begin n_errors++; $display("FAIL reset_addr: got %h expected 00", addr_a); end
        n_checks++;
        if (data_a !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", data_a); end
        n_checks++;
        if (wren_a !== 1'b0) begin n_errors++; $display("FAIL reset_wren: got %b expected 0", wren_a); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++;
        if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_checks++;
        if ({addr_b, data_b, wren_b, busy_b, done_b} !== 19'h0) begin
            n_errors++;
            $display("FAIL reset_b_outputs: got %h expected 0", {addr_b, data_b, wren_b, busy_b, done_b});
        end
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_key249();
        int lat;
        bit bd;
        logic [63:0] first;
        preload(1'b0, rand_bytes());
        set_key(24'h000249, 3);
        model_run(rand_bytes(), 1'b1, 3);
        run(1'b0, 1'b1, 24'h000249, -1, lat, bd);
        n_checks++;
        if (lat != 2305) begin n_errors++; $display("FAIL key249_latency: got %0d expected 2305", lat); end
        n_checks++;
        if (bd !== 1'b0) begin n_errors++; $display("FAIL key249_busy_at_done: got %b expected 0", bd); end
        first = (wlog.size() >= 260) ? {wlog[256], wlog[257], wlog[258], wlog[259]} : '1;
        n_checks++;
        if (first !== 64'h0000_0000_0301_0103) begin
            n_errors++;
            $display("FAIL key249_first_swaps: got %h expected 0000000003010103", first);
        end
        n_checks++;
        if (log_diff() != -1) begin n_errors++; $display("FAIL key249_write_log: first diff at %0d, expected none", log_diff()); end
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL key249_final_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0) begin n_errors++; $display("FAIL key249_done_pulse: got %b expected 0", done_a); end
    endtask

    task automatic test_short_key_lat3();
        int lat;
        bit bd;
        preload(1'b1, rand_bytes());
        set_key(24'h0000FF, 1);
        model_run(rand_bytes(), 1'b1, 1);
        run(1'b1, 1'b1, 24'h0000FF, -1, lat, bd);
        n_checks++;
        if (lat != 3329) begin n_errors++; $display("FAIL lat3_latency: got %0d expected 3329", lat); end
        n_checks++;
        if (log_diff() != -1) begin n_errors++; $display("FAIL lat3_write_log: first diff at %0d, expected none", log_diff()); end
        n_checks++;
        if (mem_diff(1'b1) != 0) begin n_errors++; $display("FAIL lat3_final_s: %0d bytes differ, expected 0", mem_diff(1'b1)); end
    endtask

    task automatic test_no_init();
        int    lat;
        bit    bd;
        sarr_t rev;
        for (int k = 0; k < 256; k++) rev[k] = 8'(255 - k);
        preload(1'b0, rev);
        set_key(24'h123456, 3);
        model_run(rev, 1'b0, 3);
        run(1'b0, 1'b0, 24'h123456, -1, lat, bd);
        n_checks++;
        if (lat != 2049) begin n_errors++; $display("FAIL noinit_latency: got %0d expected 2049", lat); end
        n_checks++;
        if (wlog.size() != 512) begin n_errors++; $display("FAIL noinit_write_count: got %0d expected 512", wlog.size()); end
        n_checks++;
        if (log_diff() != -1) begin n_errors++; $display("FAIL noinit_write_log: first diff at %0d, expected none", log_diff()); end
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL noinit_final_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
    endtask

    task automatic test_start_ignored();
        int          lat;
        bit          bd;
        logic [23:0] k1 = 24'($urandom);
        set_key(k1, 3);
        model_run(rand_bytes(), 1'b1, 3);
        run(1'b0, 1'b1, k1, 100, lat, bd);
        n_checks++;
        if (lat != 2305) begin n_errors++; $display("FAIL ignored_latency: got %0d expected 2305", lat); end
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL ignored_final_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
    endtask

    task automatic test_reset_mid();
        int          lat;
        bit          bd;
        int          dones = 0;
        logic [23:0] k = 24'($urandom);
        @(negedge clk);
        start_a = 1'b1; init_a = 1'b1; key_a = 24'hC0FFEE;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 1; n < 500; n++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        reset = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({addr_a, data_a, wren_a, busy_a, done_a} !== 19'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {addr_a, data_a, wren_a, busy_a, done_a});
        end
        reset = 1'b0;
        start_a = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (done_a) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0) begin n_errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
        set_key(k, 3);
        model_run(rand_bytes(), 1'b1, 3);
        run(1'b0, 1'b1, k, -1, lat, bd);
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL midreset_rerun_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bd;
        set_key(24'h000001, 3);
        model_run(rand_bytes(), 1'b1, 3);
        run(1'b0, 1'b1, 24'h000001, -1, lat, bd);
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL b2b_first_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
        set_key(24'h000002, 3);
        model_run(rand_bytes(), 1'b1, 3);
        run(1'b0, 1'b1, 24'h000002, -1, lat, bd);
        n_checks++;
        if (lat != 2305) begin n_errors++; $display("FAIL b2b_second_latency: got %0d expected 2305", lat); end
        n_checks++;
        if (log_diff() != -1) begin n_errors++; $display("FAIL b2b_second_log: first diff at %0d, expected none", log_diff()); end
        n_checks++;
        if (mem_diff(1'b0) != 0) begin n_errors++; $display("FAIL b2b_second_s: %0d bytes differ, expected 0", mem_diff(1'b0)); end
    endtask

    task automatic test_random();
        int          lat;
        bit          bd;
        bit          ie;
        bit          sel;
        int          klen;
        int          exp_lat;
        sarr_t       s0;
        logic [23:0] k;
        for (int r = 0; r < 3; r++) begin
            sel  = (r == 2);
            klen = sel ? 1 : 3;
            ie   = 1'($urandom_range(0, 1));
            k    = 24'($urandom);
            if (sel) k = {16'h0, k[7:0]};
            s0   = ie ? rand_bytes() : rand_perm();
            preload(sel, s0);
            set_key(k, klen);
            model_run(s0, ie, klen);
            run(sel, ie, k, -1, lat, bd);
            exp_lat = 1 + (ie ? 256 : 0) + 256 * (sel ? 12 : 8);
            n_checks++;
            if (lat != exp_lat) begin n_errors++; $display("FAIL random%0d_latency: got %0d expected %0d", r, lat, exp_lat); end
            n_checks++;
            if (log_diff() != -1) begin n_errors++; $display("FAIL random%0d_write_log: first diff at %0d, expected none", r, log_diff()); end
            n_checks++;
            if (mem_diff(sel) != 0) begin n_errors++; $display("FAIL random%0d_final_s: %0d bytes differ, expected 0", r, mem_diff(sel)); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_a = 1'b0; init_a = 1'b0; key_a = '0;
        start_b = 1'b0; init_b = 1'b0; key_b = '0;
        test_reset();
        test_key249();
        test_short_key_lat3();
        test_no_init();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
